// File: rtl/sys_reg_pkg.sv
// Shared constants for the special-register file: register indices and
// NZCV positions within the top nibble of CPSR.
package sys_reg_pkg;

    localparam logic [2:0] REG_ZR   = 3'd0;
    localparam logic [2:0] REG_R1   = 3'd1;
    localparam logic [2:0] REG_R2   = 3'd2;
    localparam logic [2:0] REG_R3   = 3'd3;
    localparam logic [2:0] REG_SP   = 3'd4;
    localparam logic [2:0] REG_LR   = 3'd5;
    localparam logic [2:0] REG_PC   = 3'd6;
    localparam logic [2:0] REG_CPSR = 3'd7;

    // Offsets inside the 4-bit flag field; CPSR bit = DATA_WIDTH-4+offset.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/sys_stack_ptr.sv
// Stack pointer with push/pop, bounds checking against [SP_LIMIT, SP_RESET]
// and a sticky fault flag that only reset or a direct SP write clears.
module sys_stack_ptr #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   SP_RESET   = 32'h0000_FFFC,
    parameter logic [DATA_WIDTH-1:0]   SP_LIMIT   = 32'h0000_F000,
    parameter logic [DATA_WIDTH-1:0]   SP_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] sp,
    output logic                  fault
);

    logic [DATA_WIDTH-1:0] sp_q, sp_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH:0]   push_ext, pop_ext;
    logic                  push_bad, pop_bad;

    // One extra bit so a wrap past zero or past all-ones is seen as a fault.
    assign push_ext = {1'b0, sp_q} - {1'b0, SP_STEP};
    assign pop_ext  = {1'b0, sp_q} + {1'b0, SP_STEP};
    assign push_bad = push_ext[DATA_WIDTH] || (push_ext[DATA_WIDTH-1:0] < SP_LIMIT);
    assign pop_bad  = pop_ext > {1'b0, SP_RESET};

    always_comb begin
        sp_d    = sp_q;
        fault_d = fault_q;
        if (wr_en) begin
            sp_d    = wr_data;
            fault_d = 1'b0;
        end else if (push && !pop) begin
            if (push_bad) fault_d = 1'b1;
            else          sp_d    = push_ext[DATA_WIDTH-1:0];
        end else if (pop && !push) begin
            if (pop_bad) fault_d = 1'b1;
            else         sp_d    = pop_ext[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= SP_RESET;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    assign sp    = sp_q;
    assign fault = fault_q;

endmodule

// File: rtl/sys_reg_file.sv
// Special-register file: ZR, R1-R3, SP, LR, PC, CPSR with fetch, BL link,
// stack and flag channels alongside a generic user read/write port.
module sys_reg_file
    import sys_reg_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   PC_RESET   = 0,
    parameter logic [DATA_WIDTH-1:0]   PC_STEP    = 4,
    parameter logic [DATA_WIDTH-1:0]   SP_RESET   = 32'h0000_FFFC,
    parameter logic [DATA_WIDTH-1:0]   SP_LIMIT   = 32'h0000_F000,
    parameter logic [DATA_WIDTH-1:0]   SP_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usr_wr_en,
    input  logic [2:0]            usr_wr_addr,
    input  logic [DATA_WIDTH-1:0] usr_wr_data,
    input  logic [2:0]            usr_rd_addr,
    output logic [DATA_WIDTH-1:0] usr_rd_data,
    input  logic                  pc_inc,
    input  logic                  pc_ld,
    input  logic [DATA_WIDTH-1:0] pc_ld_data,
    input  logic                  lr_save,
    input  logic                  sp_push,
    input  logic                  sp_pop,
    input  logic                  flags_wr,
    input  logic [3:0]            flags_mask,
    input  logic [3:0]            flags_in,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] sp_out,
    output logic [DATA_WIDTH-1:0] lr_out,
    output logic [DATA_WIDTH-1:0] cpsr_out,
    output logic                  sp_fault
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] lr_q, lr_d;
    logic [DATA_WIDTH-1:0] cpsr_q, cpsr_d;
    logic [DATA_WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [DATA_WIDTH-1:0] sp_val;

    logic wr_r1, wr_r2, wr_r3, wr_sp, wr_lr, wr_pc, wr_cpsr;

    assign wr_r1   = usr_wr_en && (usr_wr_addr == REG_R1);
    assign wr_r2   = usr_wr_en && (usr_wr_addr == REG_R2);
    assign wr_r3   = usr_wr_en && (usr_wr_addr == REG_R3);
    assign wr_sp   = usr_wr_en && (usr_wr_addr == REG_SP);
    assign wr_lr   = usr_wr_en && (usr_wr_addr == REG_LR);
    assign wr_pc   = usr_wr_en && (usr_wr_addr == REG_PC);
    assign wr_cpsr = usr_wr_en && (usr_wr_addr == REG_CPSR);

    sys_stack_ptr #(
        .DATA_WIDTH (DATA_WIDTH),
        .SP_RESET   (SP_RESET),
        .SP_LIMIT   (SP_LIMIT),
        .SP_STEP    (SP_STEP)
    ) u_stack_ptr (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_sp),
        .wr_data (usr_wr_data),
        .push    (sp_push),
        .pop     (sp_pop),
        .sp      (sp_val),
        .fault   (sp_fault)
    );

    always_comb begin
        pc_d   = pc_q;
        lr_d   = lr_q;
        cpsr_d = cpsr_q;
        r1_d   = wr_r1 ? usr_wr_data : r1_q;
        r2_d   = wr_r2 ? usr_wr_data : r2_q;
        r3_d   = wr_r3 ? usr_wr_data : r3_q;

        if (pc_ld)       pc_d = pc_ld_data;
        else if (wr_pc)  pc_d = usr_wr_data;
        else if (pc_inc) pc_d = pc_q + PC_STEP;

        // Link uses the pre-branch PC, captured on the same edge as the load.
        if (pc_ld && lr_save) lr_d = pc_q + PC_STEP;
        else if (wr_lr)       lr_d = usr_wr_data;

        if (wr_cpsr) begin
            cpsr_d = usr_wr_data;
        end else if (flags_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (flags_mask[i]) cpsr_d[DATA_WIDTH-4+i] = flags_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= PC_RESET;
            lr_q   <= '0;
            cpsr_q <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            lr_q   <= lr_d;
            cpsr_q <= cpsr_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            r3_q   <= r3_d;
        end
    end

    always_comb begin
        usr_rd_data = '0;
        case (usr_rd_addr)
            REG_R1:   usr_rd_data = r1_q;
            REG_R2:   usr_rd_data = r2_q;
            REG_R3:   usr_rd_data = r3_q;
            REG_SP:   usr_rd_data = sp_val;
            REG_LR:   usr_rd_data = lr_q;
            REG_PC:   usr_rd_data = pc_q;
            REG_CPSR: usr_rd_data = cpsr_q;
            default:  usr_rd_data = '0;
        endcase
    end

    assign pc_out   = pc_q;
    assign sp_out   = sp_val;
    assign lr_out   = lr_q;
    assign cpsr_out = cpsr_q;

endmodule

// File: tb/tb_sys_reg_file.sv
// Directed self-checking bench for sys_reg_file with hand-computed expectations.
module tb_sys_reg_file;

    logic        clk;
    logic        rst;
    logic        usr_wr_en;
    logic [2:0]  usr_wr_addr;
    logic [31:0] usr_wr_data;
    logic [2:0]  usr_rd_addr;
    logic [31:0] usr_rd_data;
    logic        pc_inc, pc_ld, lr_save;
    logic [31:0] pc_ld_data;
    logic        sp_push, sp_pop;
    logic        flags_wr;
    logic [3:0]  flags_mask, flags_in;
    logic [31:0] pc_out, sp_out, lr_out, cpsr_out;
    logic        sp_fault;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    sys_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .usr_wr_en   (usr_wr_en),
        .usr_wr_addr (usr_wr_addr),
        .usr_wr_data (usr_wr_data),
        .usr_rd_addr (usr_rd_addr),
        .usr_rd_data (usr_rd_data),
        .pc_inc      (pc_inc),
        .pc_ld       (pc_ld),
        .pc_ld_data  (pc_ld_data),
        .lr_save     (lr_save),
        .sp_push     (sp_push),
        .sp_pop      (sp_pop),
        .flags_wr    (flags_wr),
        .flags_mask  (flags_mask),
        .flags_in    (flags_in),
        .pc_out      (pc_out),
        .sp_out      (sp_out),
        .lr_out      (lr_out),
        .cpsr_out    (cpsr_out),
        .sp_fault    (sp_fault)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic clear_strobes();
        rst = 1'b0; usr_wr_en = 1'b0; pc_inc = 1'b0; pc_ld = 1'b0; lr_save = 1'b0;
        sp_push = 1'b0; sp_pop = 1'b0; flags_wr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic usr_write(input logic [2:0] addr, input logic [31:0] data);
        usr_wr_en = 1'b1; usr_wr_addr = addr; usr_wr_data = data;
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        usr_rd_addr = addr;
        #1;
        check(tag, usr_rd_data, exp);
    endtask

    initial begin
        clear_strobes();
        usr_wr_addr = 3'd0; usr_wr_data = '0; usr_rd_addr = 3'd0;
        pc_ld_data = '0; flags_mask = '0; flags_in = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_strobes();

        // Reset sweep over all eight indices via the expected queue.
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_FFFC, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("rst_idx%0d", i), 3'(i), exp_q.pop_front());
        end
        check("rst_fault", 32'(sp_fault), 32'h0);

        usr_write(3'd0, 32'h1234); step();
        read_check("zr_drop", 3'd0, 32'h0);

        usr_write(3'd1, 32'h1111); step();
        usr_write(3'd3, 32'h3333); step();
        read_check("r1_wr", 3'd1, 32'h1111);
        read_check("r3_wr", 3'd3, 32'h3333);

        // PC increment and BL.
        for (int i = 0; i < 3; i++) begin pc_inc = 1'b1; step(); end
        check("pc_inc3", pc_out, 32'h0000_000C);
        lr_save = 1'b1; step();
        check("lr_save_alone", lr_out, 32'h0);
        pc_ld = 1'b1; lr_save = 1'b1; pc_ld_data = 32'h100; step();
        check("bl_pc", pc_out, 32'h100);
        check("bl_lr", lr_out, 32'h10);
        read_check("bl_lr_rd", 3'd5, 32'h10);
        pc_ld = 1'b1; pc_inc = 1'b1; pc_ld_data = 32'h200; step();
        check("ld_over_inc", pc_out, 32'h200);
        check("lr_hold", lr_out, 32'h10);
        usr_write(3'd6, 32'h40); pc_inc = 1'b1; step();
        check("usrpc_over_inc", pc_out, 32'h40);
        usr_write(3'd6, 32'h80); pc_ld = 1'b1; pc_ld_data = 32'h300; step();
        check("ld_over_usrpc", pc_out, 32'h300);
        usr_write(3'd5, 32'h77); pc_ld = 1'b1; lr_save = 1'b1; pc_ld_data = 32'h400; step();
        check("lrsave_over_usr", lr_out, 32'h304);

        // Stack.
        sp_push = 1'b1; step();
        sp_push = 1'b1; step();
        check("push2", sp_out, 32'h0000_FFF4);
        sp_push = 1'b1; sp_pop = 1'b1; step();
        check("push_pop", sp_out, 32'h0000_FFF4);
        check("push_pop_fault", 32'(sp_fault), 32'h0);
        sp_pop = 1'b1; step();
        sp_pop = 1'b1; step();
        check("pop2_sp", sp_out, 32'h0000_FFFC);
        check("pop2_fault", 32'(sp_fault), 32'h0);
        sp_pop = 1'b1; step();
        check("pop3_sp", sp_out, 32'h0000_FFFC);
        check("pop3_fault", 32'(sp_fault), 32'h1);
        step();
        check("fault_sticky", 32'(sp_fault), 32'h1);
        usr_write(3'd4, 32'h0000_F000); step();
        check("usr_sp", sp_out, 32'h0000_F000);
        check("usr_sp_clr", 32'(sp_fault), 32'h0);
        sp_push = 1'b1; step();
        check("ovf_sp", sp_out, 32'h0000_F000);
        check("ovf_fault", 32'(sp_fault), 32'h1);
        usr_write(3'd4, 32'h0000_F004); sp_push = 1'b1; step();
        check("clr_wins_sp", sp_out, 32'h0000_F004);
        check("clr_wins_fault", 32'(sp_fault), 32'h0);
        sp_push = 1'b1; step();
        check("push_to_limit", sp_out, 32'h0000_F000);
        check("push_to_limit_f", 32'(sp_fault), 32'h0);

        // Flags.
        flags_wr = 1'b1; flags_mask = 4'b1010; flags_in = 4'b1111; step();
        check("flags_mask", cpsr_out, 32'hA000_0000);
        flags_wr = 1'b1; flags_mask = 4'b0101; flags_in = 4'b0100; step();
        check("flags_mask2", cpsr_out, 32'hE000_0000);
        flags_wr = 1'b1; flags_mask = 4'b1010; flags_in = 4'b1111; usr_write(3'd7, 32'h5); step();
        check("usr_cpsr_wins", cpsr_out, 32'h5);

        // No same-cycle bypass on the read port.
        usr_write(3'd2, 32'hDEAD); usr_rd_addr = 3'd2;
        #1;
        check("r2_old", usr_rd_data, 32'h0);
        step();
        read_check("r2_new", 3'd2, 32'hDEAD);

        // Reset wins over all strobes.
        sp_push = 1'b1; step();
        check("pre_rst_fault", 32'(sp_fault), 32'h1);
        rst = 1'b1; pc_ld = 1'b1; pc_ld_data = 32'h500; sp_push = 1'b1; flags_wr = 1'b1;
        flags_mask = 4'hF; usr_write(3'd1, 32'h9999); step();
        check("rst_pc", pc_out, 32'h0);
        check("rst_sp", sp_out, 32'h0000_FFFC);
        check("rst_lr", lr_out, 32'h0);
        check("rst_cpsr", cpsr_out, 32'h0);
        check("rst_fault2", 32'(sp_fault), 32'h0);
        read_check("rst_r1", 3'd1, 32'h0);
        read_check("rst_r2", 3'd2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sys_reg_file.md
# sys_reg_file

Parametrised special-register file for the Single Cycle Computer: ZR, three scratch registers, SP, LR, PC and CPSR. It adds PC auto-increment and branch load, BL link capture, SP push/pop with limit checking, and masked NZCV flag updates, alongside a generic user read/write port. It sits between the control unit and the datapath; fetch, stack and flag logic use the dedicated channels, and MOV-to/from-special instructions use the user port.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every register
- PC_RESET, 0, PC value after reset
- PC_STEP, 4, PC increment per instruction; also the BL link offset
- SP_RESET, 32'h0000_FFFC, SP value after reset; also the stack top
- SP_LIMIT, 32'h0000_F000, lowest legal SP value
- SP_STEP, 4, bytes per push/pop

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- usr_wr_en  in  1  user write strobe
- usr_wr_addr  in  3  user write index (0 ZR … 7 CPSR)
- usr_wr_data  in  DATA_WIDTH  user write data
- usr_rd_addr  in  3  user read index
- usr_rd_data  out  DATA_WIDTH  combinational read of the indexed register
- pc_inc  in  1  PC <= PC + PC_STEP
- pc_ld  in  1  PC <= pc_ld_data (branch)
- pc_ld_data  in  DATA_WIDTH  branch target
- lr_save  in  1  with pc_ld: LR <= PC + PC_STEP (BL)
- sp_push  in  1  SP <= SP − SP_STEP
- sp_pop  in  1  SP <= SP + SP_STEP
- flags_wr  in  1  CPSR flag update strobe
- flags_mask  in  4  per-bit enable, [3:0] = N,Z,C,V
- flags_in  in  4  new N,Z,C,V values
- pc_out, sp_out, lr_out, cpsr_out  out  DATA_WIDTH  direct register taps
- sp_fault  out  1  sticky stack overflow/underflow flag

## Operation
- ZR: reads always 0. Writes to index 0 are dropped.
- R1–R3: writable only through the user port.
- PC priority, highest first: pc_ld, then user write to 7… no, user write to index 6, then pc_inc, then hold.
- LR priority: lr_save (only when pc_ld=1), then user write to index 5, then hold. lr_save without pc_ld is ignored.
- SP priority: user write to index 4, then push/pop, then hold.
  - push and pop together: no change, no fault.
  - A push whose result would be < SP_LIMIT, or a pop whose result would be > SP_RESET: SP holds and sp_fault sets.
  - Comparisons are unsigned. The next-value computation uses DATA_WIDTH+1 bits so that wrap-around counts as a fault.
- sp_fault is sticky. It is cleared by rst or by a user write to SP. If a fault and the clear occur in the same cycle, the clear wins.
- CPSR: flags occupy bits [DATA_WIDTH-1:DATA_WIDTH-4] = N,Z,C,V. On flags_wr, each bit with mask=1 takes flags_in; all other bits hold. A user write to index 7 overrides flags_wr entirely in that cycle.
- Reset values: PC=PC_RESET, SP=SP_RESET, all other registers 0, sp_fault=0, so usr_rd_data=0 at index 0.

## Timing
- All register updates occur on the rising edge of clk. Write-to-read latency is 1 cycle.
- Reads (usr_rd_data and the direct taps) are combinational from current state. There is no same-cycle write bypass: a read of a register being written returns the old value.
- lr_save captures the pre-branch PC + PC_STEP in the same edge that PC loads the target.
- rst asserted in the same cycle as any strobe: reset wins and all strobes are ignored.

## Structure
- Shared package sys_reg_pkg:
  - index constants REG_ZR=0, REG_R1..REG_R3=1..3, REG_SP=4, REG_LR=5, REG_PC=6, REG_CPSR=7
  - flag bit offsets FLAG_N/Z/C/V
- Sub-module sys_stack_ptr: SP register, push/pop arithmetic, limit check and sticky sp_fault, parametrised by DATA_WIDTH, SP_RESET, SP_LIMIT, SP_STEP.
- The top level holds PC, LR, CPSR, R1–R3, the write-priority muxing and the read mux.

## Test plan
- Reset, then read indices 0–7 → PC=0, SP=0xFFFC, all others 0. Write 0x1234 to index 0 → reads back 0.
- pc_inc for 3 cycles, then pc_ld=1 with lr_save=1 and pc_ld_data=0x100 → PC=0x100, LR=0x10. Same cycle with pc_inc=1 → PC=0x100.
- Push twice → SP=0xFFF4. Pop and push in the same cycle → SP=0xFFF4. Pop 3 times → SP=0xFFFC and sp_fault=1 on the 3rd pop. User write SP=0xF000 → sp_fault=0. Push → SP=0xF000, sp_fault=1.
- flags_wr with mask=1010 and in=1111, starting from CPSR=0 → CPSR=0xA000_0000. The same update plus a user write of 0x5 to index 7 → CPSR=0x5.
- User write R2=0xDEAD with usr_rd_addr=2 in the same cycle → read returns 0, then 0xDEAD on the next cycle.
- Assert rst during a cycle with pc_ld=1, sp_push=1, flags_wr=1 → all registers return to reset values and sp_fault=0.
